// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_sel_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Display-side bundle: enable and BCD digits in, anodes/segments/frame pulse out.
interface sseg_scan_ctrl_if;
  logic       en;
  logic [3:0] d3, d2, d1, d0;
  logic [7:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  modport master (output en, d3, d2, d1, d0, input an, sseg, frame_tick);
  modport slave  (input en, d3, d2, d1, d0, output an, sseg, frame_tick);
endinterface

// File: rtl/sseg_scan_ctrl_bcd.sv
// Combinational BCD to active-low seven-segment decode; codes 10..15 show a dash.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment driver with per-frame digit snapshot,
// leading-zero blanking and a fixed decimal point.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DP_POS      = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sseg_scan_ctrl_if.slave bus
);

  localparam int                PRE_W    = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam digit_sel_t        DP_SEL   = digit_sel_t'(DP_POS);

  logic [PRE_W-1:0]                 pre;
  digit_sel_t                       sel;
  logic [NUM_DIGITS-1:0][3:0]       snap;
  logic [NUM_DIGITS-1:0]            blank;
  logic [7:0]                       an_q, sseg_q;
  logic [6:0]                       pat, seg_nxt;
  logic                             tc, dp_n, lz;

  assign tc             = bus.en && (pre == PRE_LAST);
  assign bus.frame_tick = tc && (sel == digit_sel_t'(NUM_DIGITS - 1));
  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;

  // Walk down from the top digit; a digit blanks only while everything above it is zero.
  always_comb begin
    blank = '0;
    lz    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz       = lz && (snap[k] == 4'd0);
      blank[k] = (BLANK_LZ != 0) && (k > DP_POS) && lz;
    end
  end

  bcd_to_sseg u_dec (
    .bcd (snap[sel]),
    .seg (pat)
  );

  assign seg_nxt = blank[sel] ? SEG_BLANK : pat;
  assign dp_n    = !((sel == DP_SEL) && !blank[sel]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      sel    <= '0;
      snap   <= '0;
      an_q   <= 8'hFF;
      sseg_q <= 8'hFF;
    end else if (bus.en) begin
      pre    <= tc ? '0 : pre + 1'b1;
      if (tc) sel <= sel + 1'b1;
      if (bus.frame_tick) snap <= {bus.d3, bus.d2, bus.d1, bus.d0};
      an_q   <= {4'hF, ~(4'b0001 << sel)};
      sseg_q <= {dp_n, seg_nxt};
    end else begin
      an_q   <= 8'hFF;
      sseg_q <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: blanking and non-blanking instances share stimulus;
// each expected frame is queued when its digits are driven and popped as it is shown.
module tb_sseg_scan_ctrl;

  typedef struct packed {
    logic [31:0] seg;   // blanking instance, digit k at [8k+:8]
    logic [31:0] nb;    // non-blanking instance
  } frame_exp_t;

  typedef struct packed {
    logic [15:0] d;     // {d3,d2,d1,d0}
    logic [31:0] seg;
    logic [31:0] nb;
  } vec_t;

  localparam int NVEC = 10;
  localparam frame_exp_t ZERO_FRAME = '{seg: 32'hFFFF40C0, nb: 32'hC0C040C0};

  logic clk, rst_n, en;
  logic [3:0] d3, d2, d1, d0;
  int n_vec, n_err;
  frame_exp_t sb[$];
  vec_t vecs [NVEC];

  sseg_scan_ctrl_if bus_lz ();
  sseg_scan_ctrl_if bus_nb ();

  assign bus_lz.en = en;
  assign bus_lz.d3 = d3;
  assign bus_lz.d2 = d2;
  assign bus_lz.d1 = d1;
  assign bus_lz.d0 = d0;
  assign bus_nb.en = en;
  assign bus_nb.d3 = d3;
  assign bus_nb.d2 = d2;
  assign bus_nb.d1 = d1;
  assign bus_nb.d0 = d0;

  sseg_scan_ctrl #(.REFRESH_DIV(4), .DP_POS(1), .BLANK_LZ(1)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus_lz)
  );
  sseg_scan_ctrl #(.REFRESH_DIV(4), .DP_POS(1), .BLANK_LZ(0)) dut_nb (
    .clk (clk), .rst_n (rst_n), .bus (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic set_d(input logic [15:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  // Called aligned to the first displayed cycle of a frame; checks the whole frame
  // (plus any enable gap) against the queue front, then pops it.
  task automatic check_frame(input int gap_start, input int gap_len,
                             input int chg_cycle, input logic [3:0] chg_val);
    frame_exp_t e;
    int eff, k;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty @%0t: got no expected frame, want one", $time);
      return;
    end
    e = sb[0];
    for (int c = 1; c <= 16 + gap_len; c++) begin
      @(negedge clk);
      if (gap_len > 0 && c > gap_start && c <= gap_start + gap_len) eff = 0;
      else if (gap_len > 0 && c > gap_start + gap_len)                 eff = c - gap_len;
      else                                                             eff = c;
      if (eff == 0) begin
        chk("an_off",   bus_lz.an,   8'hFF);
        chk("sseg_off", bus_lz.sseg, 8'hFF);
        chk("nb_off",   bus_nb.sseg, 8'hFF);
        chk("tick_off", {7'd0, bus_lz.frame_tick}, 8'h00);
      end else begin
        k = (eff - 1) / 4;
        chk("an",    bus_lz.an,   8'hFF ^ (8'h01 << k));
        chk("an_nb", bus_nb.an,   8'hFF ^ (8'h01 << k));
        chk("sseg",  bus_lz.sseg, e.seg[8*k +: 8]);
        chk("sseg_nb", bus_nb.sseg, e.nb[8*k +: 8]);
        chk("tick",  {7'd0, bus_lz.frame_tick}, {7'd0, eff == 15});
      end
      if (c == chg_cycle) d0 = chg_val;
      if (gap_len > 0 && c == gap_start)           en = 1'b0;
      if (gap_len > 0 && c == gap_start + gap_len) en = 1'b1;
    end
    void'(sb.pop_front());
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{d: 16'h1234, seg: 32'hF9A43099, nb: 32'hF9A43099};
    vecs[1] = '{d: 16'h0005, seg: 32'hFFFF4092, nb: 32'hC0C04092};
    vecs[2] = '{d: 16'h0047, seg: 32'hFFFF19F8, nb: 32'hC0C019F8};
    vecs[3] = '{d: 16'h0000, seg: 32'hFFFF40C0, nb: 32'hC0C040C0};
    vecs[4] = '{d: 16'h000C, seg: 32'hFFFF40BF, nb: 32'hC0C040BF};
    vecs[5] = '{d: 16'h0908, seg: 32'hFF904080, nb: 32'hC0904080};
    vecs[6] = '{d: 16'h5000, seg: 32'h92C040C0, nb: 32'h92C040C0};
    vecs[7] = '{d: 16'hFA00, seg: 32'hBFBF40C0, nb: 32'hBFBF40C0};
    vecs[8] = '{d: 16'h0100, seg: 32'hFFF940C0, nb: 32'hC0F940C0};
    vecs[9] = '{d: 16'h0060, seg: 32'hFFFF02C0, nb: 32'hC0C002C0};

    rst_n = 1'b0;
    en    = 1'b1;
    set_d(16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_an",   bus_lz.an,   8'hFF);
    chk("rst_sseg", bus_lz.sseg, 8'hFF);
    chk("rst_tick", {7'd0, bus_lz.frame_tick}, 8'h00);
    rst_n = 1'b1;

    // First frame shows the all-zero snapshot; each vector appears one frame after it is driven.
    sb.push_back(ZERO_FRAME);
    for (int i = 0; i < NVEC; i++) begin
      set_d(vecs[i].d);
      sb.push_back('{seg: vecs[i].seg, nb: vecs[i].nb});
      check_frame(0, 0, 0, 4'd0);
    end

    // Mid-frame d0 change: the frame in progress keeps 5, the following one shows 6.
    set_d(16'h0005);
    sb.push_back('{seg: 32'hFFFF4092, nb: 32'hC0C04092});
    check_frame(0, 0, 0, 4'd0);
    sb.push_back('{seg: 32'hFFFF4082, nb: 32'hC0C04082});
    check_frame(0, 0, 6, 4'd6);

    // Enable drop for 10 cycles inside digit 0; scan resumes where it stopped.
    sb.push_back('{seg: 32'hFFFF4082, nb: 32'hC0C04082});
    check_frame(0, 0, 0, 4'd0);
    check_frame(2, 10, 0, 4'd0);

    // Asynchronous reset while digit 2 is selected.
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_an",   bus_lz.an,   8'hFF);
    chk("mrst_sseg", bus_lz.sseg, 8'hFF);
    chk("mrst_nb",   bus_nb.sseg, 8'hFF);
    chk("mrst_tick", {7'd0, bus_lz.frame_tick}, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    sb.push_back(ZERO_FRAME);
    set_d(vecs[0].d);
    sb.push_back('{seg: vecs[0].seg, nb: vecs[0].nb});
    check_frame(0, 0, 0, 4'd0);
    check_frame(0, 0, 0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
